// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter that shares one external 4-bit Mealy sequence detector between two requesters.
// Optional per-requester saturating match counters are present when SEQ_ARB_CNT_EN is defined.
module seq_det_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_data,
  output logic             req1_ready,
  output logic             det_in,
  output logic             det_clr_n,
  input  logic             det_dec,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic             res_match,
  output logic [3:0]       res_data,
  input  logic             cnt_clr
`ifdef SEQ_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt0,
  output logic [CNT_W-1:0] match_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic [3:0] shreg;
  logic [3:0] word_q;
  logic       id_q;
  logic [1:0] bit_cnt;
  logic       match;
  logic       res_id_q;
  logic [3:0] res_data_q;
  logic       grant_vld;
  logic       grant_id;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_vld = 1'b1;
          grant_id  = ~last_grant;
        end else if (req0_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end else if (req1_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        if (grant_vld) state_nxt = CLEAR;
      end
      CLEAR:   state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 2'd0) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // word_q keeps the original frame because shreg is consumed while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      shreg      <= 4'd0;
      word_q     <= 4'd0;
      id_q       <= 1'b0;
      bit_cnt    <= 2'd0;
      match      <= 1'b0;
      res_id_q   <= 1'b0;
      res_data_q <= 4'd0;
    end else begin
      case (state)
        IDLE: if (grant_vld) begin
          shreg      <= grant_id ? req1_data : req0_data;
          word_q     <= grant_id ? req1_data : req0_data;
          id_q       <= grant_id;
          last_grant <= grant_id;
        end
        CLEAR: bit_cnt <= 2'd3;
        SHIFT: begin
          shreg   <= {shreg[2:0], 1'b0};
          bit_cnt <= bit_cnt - 2'd1;
          if (bit_cnt == 2'd0) begin
            match      <= det_dec;
            res_id_q   <= id_q;
            res_data_q <= word_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld & grant_id;
  assign busy       = (state != IDLE);
  assign res_valid  = (state == REPORT);
  assign res_id     = res_id_q;
  assign res_match  = match;
  assign res_data   = res_data_q;
  assign det_in     = (state == SHIFT) & shreg[3];
  // The detector is held in clear for the whole of reset, not just after it.
  assign det_clr_n  = rst_n & (state != CLEAR);

`ifdef SEQ_ARB_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt0 <= '0;
      match_cnt1 <= '0;
    end else if (cnt_clr) begin
      match_cnt0 <= '0;
      match_cnt1 <= '0;
    end else if (state == REPORT && match) begin
      if (!res_id_q && match_cnt0 != CNT_MAX) match_cnt0 <= match_cnt0 + CNT_W'(1);
      if (res_id_q && match_cnt1 != CNT_MAX)  match_cnt1 <= match_cnt1 + CNT_W'(1);
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter with a behavioural model of the external 4-bit frame detector.
module tb_seq_det_arbiter;

  logic       clk, rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_data, req1_data;
  logic       det_in, det_clr_n, det_dec;
  logic       busy, res_valid, res_id, res_match;
  logic [3:0] res_data;
  logic       cnt_clr;
`ifdef SEQ_ARB_CNT_EN
  logic [1:0] match_cnt0, match_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  seq_det_arbiter #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_in(det_in), .det_clr_n(det_clr_n), .det_dec(det_dec),
    .busy(busy), .res_valid(res_valid), .res_id(res_id), .res_match(res_match),
    .res_data(res_data), .cnt_clr(cnt_clr)
`ifdef SEQ_ARB_CNT_EN
    , .match_cnt0(match_cnt0), .match_cnt1(match_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector: synchronous clear, flags 0111/1110 only on the 4th bit after clear.
  logic [2:0] det_hist;
  logic [2:0] det_n;
  always @(posedge clk) begin
    if (!det_clr_n) begin
      det_hist <= 3'd0;
      det_n    <= 3'd0;
    end else begin
      det_hist <= {det_hist[1:0], det_in};
      if (det_n != 3'd4) det_n <= det_n + 3'd1;
    end
  end
  assign det_dec = (det_n == 3'd3) &&
                   (({det_hist, det_in} == 4'b0111) || ({det_hist, det_in} == 4'b1110));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cnts(input string tag);
`ifdef SEQ_ARB_CNT_EN
    check({tag, " cnt0"}, 32'(match_cnt0), exp_cnt0);
    check({tag, " cnt1"}, 32'(match_cnt1), exp_cnt1);
`else
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
`endif
  endtask

  typedef struct {
    logic       v0;
    logic [3:0] d0;
    logic       v1;
    logic [3:0] d1;
    logic       clr;
    logic       exp_id;
    logic       exp_match;
  } frame_t;

  // Entered 1 ns after the acceptance edge's preceding posedge; returns 1 ns after the T+7 edge.
  task automatic run_frame(input frame_t f, input string tag);
    logic [3:0] wd;
    wd = f.exp_id ? f.d1 : f.d0;
    req0_valid = f.v0; req0_data = f.d0;
    req1_valid = f.v1; req1_data = f.d1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check({tag, " ready0"}, 32'(req0_ready), 32'(f.exp_id == 1'b0));
    check({tag, " ready1"}, 32'(req1_ready), 32'(f.exp_id == 1'b1));
    check({tag, " busy_T"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check({tag, " clr_n"}, 32'(det_clr_n), 32'd0);
    check({tag, " clr_in"}, 32'(det_in), 32'd0);
    check({tag, " clr_rdy"}, 32'({req0_ready, req1_ready}), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("%s det_in%0d", tag, k), 32'(det_in), 32'(wd[3-k]));
      check($sformatf("%s shf%0d", tag, k), 32'({det_clr_n, busy, res_valid}), 32'b110);
    end
    @(posedge clk); #1;
    cnt_clr = f.clr;
    @(negedge clk);
    check({tag, " res_valid"}, 32'(res_valid), 32'd1);
    check({tag, " res_id"}, 32'(res_id), 32'(f.exp_id));
    check({tag, " res_match"}, 32'(res_match), 32'(f.exp_match));
    check({tag, " res_data"}, 32'(res_data), 32'(wd));
    if (f.clr) begin
      exp_cnt0 = 0;
      exp_cnt1 = 0;
    end else if (f.exp_match) begin
      if (!f.exp_id && exp_cnt0 < 3) exp_cnt0++;
      if (f.exp_id && exp_cnt1 < 3)  exp_cnt1++;
    end
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check({tag, " hold"}, 32'({res_valid, busy, res_id, res_data}), 32'({2'b00, f.exp_id, wd}));
    check_cnts(tag);
  endtask

  frame_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'b0011, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'b0011, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; cnt_clr = 1'b0;
    req0_valid = 1'b0; req0_data = 4'd0;
    req1_valid = 1'b0; req1_data = 4'd0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst det", 32'({det_clr_n, det_in}), 32'd0);
    check("rst res", 32'({res_valid, res_id, res_match, res_data}), 32'd0);
    check_cnts("rst");
    rst_n = 1'b1;

    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      check("idle", 32'({req0_ready, req1_ready, busy, det_in, res_valid}), 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_frame(tbl[i], $sformatf("f%0d", i));

    // Reset during the second SHIFT cycle of a frame.
    req0_valid = 1'b1; req0_data = 4'b0111;
    @(negedge clk);
    check("mid ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid pre", 32'({busy, det_in}), 32'b11);
    rst_n = 1'b0;
    #1;
    check("mid busy", 32'(busy), 32'd0);
    check("mid det", 32'({det_clr_n, det_in}), 32'd0);
    check("mid res", 32'({res_valid, res_id, res_match, res_data}), 32'd0);
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    check_cnts("mid");
    repeat (3) begin
      @(negedge clk);
      check("mid hold", 32'({res_valid, det_clr_n, busy}), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame('{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1}, "post0");
    run_frame('{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1}, "post1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Round-robin scheduler that shares one external 4-bit-frame Mealy sequence detector between two requesters. Each requester offers a 4-bit word on a valid/ready handshake. The winner's word is loaded, the detector is cleared, and the word is shifted MSB-first into the detector's serial input. The block samples the detector's `dec` on the fourth bit and reports a tagged match result. It sits between the frame producers and the detector, and owns the detector's `in` and `rst_n` pins.

## Interface
- `CNT_W`, default 8: width of each per-requester match counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid`  in  1  requester 0 offers a word.
- `req0_data`  in  4  requester 0 word; bit 3 is sent first.
- `req0_ready`  out  1  requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `det_in`  out  1  serial bit to the detector `in`.
- `det_clr_n`  out  1  to the detector `rst_n`; the detector samples it synchronously.
- `det_dec`  in  1  detector `dec`; combinational Mealy output.
- `busy`  out  1  high whenever state ≠ IDLE.
- `res_valid`  out  1  one-cycle result strobe.
- `res_id`  out  1  requester the result belongs to.
- `res_match`  out  1  `1` when the word was `0111` or `1110`.
- `res_data`  out  4  word that was checked.
- `cnt_clr`  in  1  synchronous clear of both match counters.
- `match_cnt0`, `match_cnt1`  out  `CNT_W` each  saturating match counts per requester; present only with `SEQ_ARB_CNT_EN`.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, REPORT.
- **IDLE**
  - No valid requests: stay in IDLE.
  - Exactly one valid: grant it.
  - Both valid: grant the requester ≠ `last_grant`.
  - On a grant, assert that requester's `reqX_ready` combinationally in the same cycle.
  - At the edge: load `shreg` from its data, store `id`, update `last_grant`, go to CLEAR.
- **CLEAR**
  - Drive `det_clr_n`=0 and `det_in`=0, so the detector is in its start state before bit 3.
  - Set `bit_cnt`=3, go to SHIFT.
- **SHIFT**
  - Drive `det_in`=`shreg[3]`.
  - At each edge: shift `shreg` left, decrement `bit_cnt`.
  - When `bit_cnt`=0, capture `det_dec` into `match` at that edge, then go to REPORT.
- **REPORT**
  - Drive `res_valid`=1 with `res_id`, `res_match`, `res_data`.
  - Update the granted requester's counter, then go to IDLE.
- `res_id`, `res_match` and `res_data` hold their values until the next REPORT.
- `reqX_ready` is never high outside IDLE and never high for both requesters at once.
- `det_in`=0 in every state except SHIFT.
- Counters
  - Increment by 1 in REPORT when `match`=1; saturate at 2^`CNT_W`−1.
  - `cnt_clr` clears both counters; if `cnt_clr` and an increment fall in the same cycle, the clear wins.

## Timing
- Reset (async assert, sync release)
  - state=IDLE, `last_grant`=1, so requester 0 wins the first tie.
  - `shreg`=0, `match`=0, `res_*`=0, counters=0, `busy`=0.
  - While `rst_n`=0: `det_clr_n`=0 and `det_in`=0.
- Frame timeline, with acceptance in cycle T:
  - T: IDLE, grant.
  - T+1: CLEAR.
  - T+2 to T+5: SHIFT, bits 3, 2, 1, 0.
  - T+6: REPORT, `res_valid`=1.
  - T+7: IDLE; earliest next acceptance.
- Throughput: one frame per 7 cycles.
- Reset mid-frame: the frame is dropped, with no `res_valid` and no count; the detector is held in clear.
- A requester that drops `valid` before `ready` is simply not granted; no state is kept for it.

## Configuration
- `SEQ_ARB_CNT_EN` defined: `match_cnt0`, `match_cnt1` and the counter logic are present, and `cnt_clr` is functional.
- `SEQ_ARB_CNT_EN` undefined: the counter ports are removed and `cnt_clr` is ignored; all other behaviour and timing are identical.

## Test plan
- **Match on `0111`:** after reset, `req0_valid`=1, `req0_data`=`0111` → `req0_ready` at T; `det_in` = 0,1,1,1 over T+2..T+5; at T+6 `res_valid`=1, `res_id`=0, `res_match`=1; `match_cnt0`=1.
- **Match on `1110`, no match on `0110`:** `req1_data`=`1110` → `res_match`=1, `res_id`=1. Then `req1_data`=`0110` → `res_match`=0 and `match_cnt1` unchanged.
- **Simultaneous requests:** both valid from reset, `req0_data`=`0111`, `req1_data`=`1110` → grant order 0, 1, 0, 1. Results arrive 7 cycles apart, all with `res_match`=1.
- **Reset mid-frame:** pulse `rst_n` low during the second SHIFT cycle → outputs return to reset values asynchronously; no `res_valid`; `det_clr_n`=0 throughout reset; the next frame behaves normally.
- **Counter saturation and clear (`SEQ_ARB_CNT_EN`, `CNT_W`=2):** five matching frames on requester 0 → `match_cnt0` = 1, 2, 3, 3, 3. Assert `cnt_clr` in the REPORT cycle of a matching frame → count is 0.
- **Counters compiled out:** build without `SEQ_ARB_CNT_EN` and run the tests above → identical `res_*` and handshake traces.
